// File: rtl/hearts_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hearts_pkg
// Purpose : Shared definitions for the hearts/life subsystem. It is used by
//           the life manager, the hearts HUD display and the game-state FSM.
// Contents: HEARTS_W        width of a heart count
//           ALIVE/INVINCIBLE/DEAD  life FSM state encoding
//           hearts_adjust() saturating +1/-1 on a heart count
// Revision: 1.0  initial release
// ============================================================================
package hearts_pkg;

  localparam int HEARTS_W = 2;

  localparam logic [1:0] ALIVE      = 2'd0;
  localparam logic [1:0] INVINCIBLE = 2'd1;
  localparam logic [1:0] DEAD       = 2'd2;

  // Applies an optional +1 and an optional -1 to a heart count. The +1 is
  // added first so that a pickup coinciding with a hit at one heart nets
  // out to one heart. The result is clamped to 0..max_h.
  function automatic logic [HEARTS_W-1:0] hearts_adjust(
    input logic [HEARTS_W-1:0] hearts,
    input logic                inc,
    input logic                dec,
    input logic [HEARTS_W-1:0] max_h
  );
    logic [HEARTS_W:0] sum;
    sum = {1'b0, hearts} + {{HEARTS_W{1'b0}}, inc};
    if (dec) begin
      sum = (sum == '0) ? '0 : sum - {{HEARTS_W{1'b0}}, 1'b1};
    end
    if (sum > {1'b0, max_h}) begin
      sum = {1'b0, max_h};
    end
    return sum[HEARTS_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/hearts_inv_timer.sv
`default_nettype none
// ============================================================================
// Module  : hearts_inv_timer
// Purpose : Invincibility window timer. It counts frame ticks down from
//           INV_FRAMES and divides them by BLINK_FRAMES to produce the sprite
//           blink phase.
// Ports   : clk_i        system clock
//           rst_i        synchronous clear (reset or game restart)
//           load_i       start a new window, blink phase starts high
//           frame_tick_i one pulse per video frame
//           en_i         count enable (gameplay running and invincible)
//           expired_o    combinational pulse on the tick that ends the window
//           blink_o      registered blink phase, 0 outside a window
// Revision: 1.0  initial release
// ============================================================================
module hearts_inv_timer #(
  parameter int INV_FRAMES   = 120,
  parameter int BLINK_FRAMES = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic frame_tick_i,
  input  logic en_i,
  output logic expired_o,
  output logic blink_o
);

  localparam int INV_W   = $clog2(INV_FRAMES + 1);
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [INV_W-1:0]   INV_LOAD   = INV_W'(INV_FRAMES);
  localparam logic [INV_W-1:0]   INV_ONE    = INV_W'(1);
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_FRAMES);
  localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

  logic [INV_W-1:0]   inv_cnt_q,   inv_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q,     blink_d;
  logic               step;

  // A tick only counts while a window is actually running.
  assign step      = en_i & frame_tick_i & (inv_cnt_q != '0);
  assign expired_o = step & ~load_i & (inv_cnt_q == INV_ONE);

  always_comb begin
    inv_cnt_d   = inv_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (load_i) begin
      inv_cnt_d   = INV_LOAD;
      blink_cnt_d = BLINK_LOAD;
      blink_d     = 1'b1;
    end else if (expired_o) begin
      // Window over: sprite must be visible again the same cycle.
      inv_cnt_d   = '0;
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (step) begin
      inv_cnt_d = inv_cnt_q - INV_ONE;
      // Reaching zero reloads immediately, so the phase flips every
      // BLINK_FRAMES ticks exactly.
      if (blink_cnt_q == BLINK_ONE) begin
        blink_cnt_d = BLINK_LOAD;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q - BLINK_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inv_cnt_q   <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      inv_cnt_q   <= inv_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign blink_o = blink_q;

endmodule
`default_nettype wire

// File: rtl/hearts_life_manager.sv
`default_nettype none
// ============================================================================
// Module  : hearts_life_manager
// Purpose : Owns the player's life count, runs the post-hit invincibility
//           window with sprite blink, and flags game over on the last heart.
// Ports   : clk_i          system clock
//           reset_i        synchronous active-high reset
//           frame_tick_i   one pulse per video frame
//           game_en_i      1 = gameplay running, 0 = freeze (restart still works)
//           collision_i    level, player overlaps a hazard
//           heart_pickup_i pulse, heart item collected
//           restart_i      pulse, return to start-of-game state
//           num_hearts_o   current hearts 0..MAX_HEARTS
//           invincible_o   1 while invincible
//           blink_o        sprite hide phase during invincibility
//           hit_pulse_o    one-cycle pulse per accepted hit
//           game_over_o    1 once all hearts are lost
// Revision: 1.0  initial release
// ============================================================================
module hearts_life_manager
  import hearts_pkg::*;
#(
  parameter int MAX_HEARTS   = 3,
  parameter int INV_FRAMES   = 120,
  parameter int BLINK_FRAMES = 8
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                frame_tick_i,
  input  logic                game_en_i,
  input  logic                collision_i,
  input  logic                heart_pickup_i,
  input  logic                restart_i,
  output logic [HEARTS_W-1:0] num_hearts_o,
  output logic                invincible_o,
  output logic                blink_o,
  output logic                hit_pulse_o,
  output logic                game_over_o
);

  localparam logic [HEARTS_W-1:0] HEARTS_MAX = HEARTS_W'(MAX_HEARTS);

  logic [1:0]          state_q,  state_d;
  logic [HEARTS_W-1:0] hearts_q, hearts_d;
  logic                hit_q,    hit_d;
  logic                timer_load;
  logic                timer_en;
  logic                timer_expired;
  logic                timer_blink;

  // The timer only advances in INVINCIBLE; a frozen game freezes it too.
  assign timer_en = game_en_i & (state_q == INVINCIBLE);

  hearts_inv_timer #(
    .INV_FRAMES   (INV_FRAMES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_inv_timer (
    .clk_i        (clk_i),
    .rst_i        (reset_i | restart_i),
    .load_i       (timer_load),
    .frame_tick_i (frame_tick_i),
    .en_i         (timer_en),
    .expired_o    (timer_expired),
    .blink_o      (timer_blink)
  );

  always_comb begin
    state_d    = state_q;
    hearts_d   = hearts_q;
    hit_d      = 1'b0;
    timer_load = 1'b0;
    if (game_en_i) begin
      case (state_q)
        ALIVE: begin
          if (collision_i) begin
            hearts_d = hearts_adjust(hearts_q, heart_pickup_i, 1'b1, HEARTS_MAX);
            hit_d    = 1'b1;
            if (hearts_d == '0) begin
              state_d = DEAD;
            end else begin
              state_d    = INVINCIBLE;
              timer_load = 1'b1;
            end
          end else if (heart_pickup_i) begin
            hearts_d = hearts_adjust(hearts_q, 1'b1, 1'b0, HEARTS_MAX);
          end
        end
        INVINCIBLE: begin
          // Collision is masked for the whole window, including the
          // expiry cycle; a held collision lands on the next ALIVE cycle.
          if (heart_pickup_i) begin
            hearts_d = hearts_adjust(hearts_q, 1'b1, 1'b0, HEARTS_MAX);
          end
          if (timer_expired) begin
            state_d = ALIVE;
          end
        end
        DEAD: begin
          state_d = DEAD;
        end
        default: begin
          state_d = ALIVE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || restart_i) begin
      state_q  <= ALIVE;
      hearts_q <= HEARTS_MAX;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hearts_q <= hearts_d;
      hit_q    <= hit_d;
    end
  end

  assign num_hearts_o = hearts_q;
  assign invincible_o = (state_q == INVINCIBLE);
  assign game_over_o  = (state_q == DEAD);
  assign hit_pulse_o  = hit_q;
  assign blink_o      = timer_blink;

endmodule
`default_nettype wire
